uart_rx_frame: RTL

- Serial receiver for the SOPC UART link: the receive-side counterpart of the core's transmitter.
- Deserializes asynchronous frames on the RX pin using the same switch-selected configuration: baud code, 7/8 data bits, parity enable, odd/even select.
- Presents each received byte to the core's I/O read port with ready, parity, framing and overrun flags.

---
 rtl/uart_rx_frame.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// UART frame receiver: synchronizes rx, samples each bit at mid-bit, and holds
// the received byte with ready, parity, framing and overrun flags for the core.
module uart_rx_frame #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] baudm,
  input  logic       bit8,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rd_strobe,
  output logic [7:0] data_out,
  output logic       rxrdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  function automatic logic [19:0] div_of(input int unsigned baud);
    return 20'((CLK_HZ + baud / 2) / baud);
  endfunction

  localparam logic [19:0] D300    = div_of(300);
  localparam logic [19:0] D1200   = div_of(1200);
  localparam logic [19:0] D2400   = div_of(2400);
  localparam logic [19:0] D4800   = div_of(4800);
  localparam logic [19:0] D9600   = div_of(9600);
  localparam logic [19:0] D19200  = div_of(19200);
  localparam logic [19:0] D38400  = div_of(38400);
  localparam logic [19:0] D57600  = div_of(57600);
  localparam logic [19:0] D115200 = div_of(115200);
  localparam logic [19:0] D230400 = div_of(230400);
  localparam logic [19:0] D460800 = div_of(460800);
  localparam logic [19:0] D921600 = div_of(921600);

  function automatic logic [19:0] full_of(input logic [3:0] code);
    logic [19:0] f;
    case (code)
      4'd0:    f = D300;
      4'd1:    f = D1200;
      4'd2:    f = D2400;
      4'd3:    f = D4800;
      4'd4:    f = D9600;
      4'd5:    f = D19200;
      4'd6:    f = D38400;
      4'd7:    f = D57600;
      4'd8:    f = D115200;
      4'd9:    f = D230400;
      4'd10:   f = D460800;
      default: f = D921600;
    endcase
    return f;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   prev_q;

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  bitn_q, bitn_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [3:0]  baud_q, baud_d;
  logic        b8_q, b8_d;
  logic        pen_q, pen_d;
  logic        ohel_q, ohel_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        ovf_q, ovf_d;

  logic        tick;
  logic [19:0] full_sh;
  logic [7:0]  byte_w;
  logic        perr_w;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign tick    = (cnt_q <= 20'd1);
  assign full_sh = full_of(baud_q);
  assign byte_w  = b8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign perr_w  = pen_q & ((^byte_w ^ par_q) != ohel_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 20'd0) ? cnt_q - 20'd1 : 20'd0;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    par_d   = par_q;
    baud_d  = baud_q;
    b8_d    = b8_q;
    pen_d   = pen_q;
    ohel_d  = ohel_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovf_d   = ovf_q;
    if (rd_strobe) begin
      rdy_d  = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
      ovf_d  = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          baud_d  = baudm;
          b8_d    = bit8;
          pen_d   = pen;
          ohel_d  = ohel;
          par_d   = 1'b0;
          cnt_d   = full_of(baudm) >> 1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            cnt_d   = full_sh;
            bitn_d  = 3'd0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = full_sh;
          if (bitn_q == {2'b11, b8_q}) begin
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bitn_d = bitn_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_d   = rx_s;
          cnt_d   = full_sh;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          // commit overrides a same-cycle read
          data_d  = byte_w;
          perr_d  = perr_w;
          ferr_d  = ~rx_s;
          ovf_d   = rdy_q & ~rd_strobe;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (reset) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      baud_q  <= '0;
      b8_q    <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      baud_q  <= baud_d;
      b8_q    <= b8_d;
      pen_q   <= pen_d;
      ohel_q  <= ohel_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = data_q;
  assign rxrdy    = rdy_q;
  assign perr     = perr_q;
  assign ferr     = ferr_q;
  assign ovf      = ovf_q;

endmodule
